// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_sync block: FSM state encoding and default sizing.
// State bit 1 is the accepted level; bits differing means a candidate is being qualified.
package debounce_pkg;

   localparam int unsigned SYNC_STAGES_DEF     = 2;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

   typedef enum logic [1:0] {
      ST_STABLE_LO = 2'b00,
      ST_CHK_HI    = 2'b01,
      ST_STABLE_HI = 2'b11,
      ST_CHK_LO    = 2'b10
   } state_t;

   // True while the FSM is qualifying a candidate level.
   function automatic logic is_chk(input state_t s);
      return s[1] ^ s[0];
   endfunction

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Plain multi-flop synchroniser for a single asynchronous level; no logic between stages.
module sync_chain #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stages;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stages <= '0;
      end else begin
         stages <= {stages[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronises and debounces a raw level; sig_clean changes only after DEBOUNCE_CYCLES stable samples.
// Optional rejected-transition counter enabled by defining GLITCH_COUNT_EN.
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int unsigned  SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned  DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
`ifdef GLITCH_COUNT_EN
   parameter int unsigned  GLITCH_W        = 8,
`endif
   localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sig_raw,
   output logic                sig_clean,
   output logic                busy
`ifdef GLITCH_COUNT_EN
   ,
   output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             glitch_evt_c;

   sync_chain #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sig_raw),
      .q     (sync_q)
   );

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_STABLE_LO;
         cnt_q     <= '0;
         sig_clean <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sig_clean <= state_d[1];
         busy      <= is_chk(state_d);
      end
   end

   // Next state: a candidate must persist for DEBOUNCE_CYCLES samples; any bounce aborts.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      glitch_evt_c = 1'b0;
      unique case (state_q)
         ST_STABLE_LO: begin
            if (sync_q) begin
               state_d = ST_CHK_HI;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_CHK_HI: begin
            if (!sync_q) begin
               state_d      = ST_STABLE_LO;
               cnt_d        = '0;
               glitch_evt_c = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_STABLE_HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_STABLE_HI: begin
            if (!sync_q) begin
               state_d = ST_CHK_LO;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_CHK_LO: begin
            if (sync_q) begin
               state_d      = ST_STABLE_HI;
               cnt_d        = '0;
               glitch_evt_c = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_STABLE_LO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef GLITCH_COUNT_EN
   // Saturating count of aborted qualifications.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         glitch_cnt <= '0;
      end else if (glitch_evt_c && (glitch_cnt != {GLITCH_W{1'b1}})) begin
         glitch_cnt <= glitch_cnt + GLITCH_W'(1);
      end
   end
`else
   logic unused_glitch;
   assign unused_glitch = glitch_evt_c;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync (defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Stimulus queues expected output transitions with their edge number; a monitor checks each change.
module tb_debounce_sync;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   logic clk;
   logic rst_n;
   logic sig_raw;
   logic sig_clean;
   logic busy;
`ifdef GLITCH_COUNT_EN
   logic [7:0] glitch_cnt;
   logic       sig_raw2;
   logic       clean2;
   logic       busy2;
   logic [1:0] glitch_cnt2;
   int         gexp;
`endif

   int   cyc;
   int   total;
   int   bad;
   int   e0;
   ev_t  q_clean[$];
   ev_t  q_busy[$];
   ev_t  q_gl[$];
   logic p_clean;
   logic p_busy;
   int   p_gl;

   debounce_sync u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_raw    (sig_raw),
      .sig_clean  (sig_clean),
      .busy       (busy)
`ifdef GLITCH_COUNT_EN
      ,
      .glitch_cnt (glitch_cnt)
`endif
   );

`ifdef GLITCH_COUNT_EN
   debounce_sync #(
      .GLITCH_W (2)
   ) u_sat (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_raw    (sig_raw2),
      .sig_clean  (clean2),
      .busy       (busy2),
      .glitch_cnt (glitch_cnt2)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk(input int c, input int v);
      ev_t e;
      e.cyc = c;
      e.val = v;
      return e;
   endfunction

   task automatic cmp_ev(input string nm, input int v, input ev_t e);
      total++;
      if (v != e.val || cyc != e.cyc) begin
         bad++;
         $display("FAIL %s: got %0d at edge %0d, want %0d at edge %0d", nm, v, cyc, e.val, e.cyc);
      end
   endtask

   task automatic unexpected(input string nm, input int v);
      total++;
      bad++;
      $display("FAIL %s: unexpected change to %0d at edge %0d", nm, v, cyc);
   endtask

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   // Monitor: every output transition must match the next queued expectation.
   always @(negedge clk) begin
      if (sig_clean !== p_clean) begin
         if (q_clean.size() == 0) unexpected("sig_clean", int'(sig_clean));
         else cmp_ev("sig_clean", int'(sig_clean), q_clean.pop_front());
         p_clean = sig_clean;
      end
      if (busy !== p_busy) begin
         if (q_busy.size() == 0) unexpected("busy", int'(busy));
         else cmp_ev("busy", int'(busy), q_busy.pop_front());
         p_busy = busy;
      end
`ifdef GLITCH_COUNT_EN
      if (int'(glitch_cnt) != p_gl) begin
         if (q_gl.size() == 0) unexpected("glitch_cnt", int'(glitch_cnt));
         else cmp_ev("glitch_cnt", int'(glitch_cnt), q_gl.pop_front());
         p_gl = int'(glitch_cnt);
      end
`endif
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Clean level change: busy edges 3..5, sig_clean at edge 6.
   task automatic step(input logic lvl);
      sig_raw = lvl;
      e0 = cyc;
      q_busy.push_back(mk(e0 + 3, 1));
      q_busy.push_back(mk(e0 + 6, 0));
      q_clean.push_back(mk(e0 + 6, int'(lvl)));
      tick(8);
   endtask

   task automatic glitch_event(input int c);
`ifdef GLITCH_COUNT_EN
      gexp++;
      q_gl.push_back(mk(c, gexp));
`else
      e0 = c;
`endif
   endtask

   initial begin
      cyc = 0; total = 0; bad = 0;
      p_clean = 1'b0; p_busy = 1'b0; p_gl = 0;
      rst_n = 1'b0;
      sig_raw = 1'b1;
`ifdef GLITCH_COUNT_EN
      sig_raw2 = 1'b0;
      gexp = 0;
`endif

      // Reset with the input held high.
      #3;
      check("reset_clean", int'(sig_clean), 0);
      check("reset_busy", int'(busy), 0);
`ifdef GLITCH_COUNT_EN
      check("reset_glitch", int'(glitch_cnt), 0);
`endif
      tick(2);
      check("reset_hold_clean", int'(sig_clean), 0);
      rst_n = 1'b1;
      e0 = cyc;
      q_busy.push_back(mk(e0 + 3, 1));
      q_busy.push_back(mk(e0 + 6, 0));
      q_clean.push_back(mk(e0 + 6, 1));
      tick(8);

      // Clean steps in both directions.
      step(1'b0);
      step(1'b1);
      step(1'b0);

      // Two-cycle high glitch is rejected.
      sig_raw = 1'b1;
      e0 = cyc;
      q_busy.push_back(mk(e0 + 3, 1));
      q_busy.push_back(mk(e0 + 5, 0));
      glitch_event(e0 + 5);
      tick(2);
      sig_raw = 1'b0;
      tick(6);
      check("glitch_clean_low", int'(sig_clean), 0);

      // Bounce train 1,0,1,0 then steady high.
      e0 = cyc;
      q_busy.push_back(mk(e0 + 3, 1));
      q_busy.push_back(mk(e0 + 4, 0));
      q_busy.push_back(mk(e0 + 5, 1));
      q_busy.push_back(mk(e0 + 6, 0));
      q_busy.push_back(mk(e0 + 7, 1));
      q_busy.push_back(mk(e0 + 10, 0));
      q_clean.push_back(mk(e0 + 10, 1));
      glitch_event(e0 + 4);
      glitch_event(e0 + 6);
      sig_raw = 1'b1; tick(1);
      sig_raw = 1'b0; tick(1);
      sig_raw = 1'b1; tick(1);
      sig_raw = 1'b0; tick(1);
      sig_raw = 1'b1;
      tick(10);
      check("bounce_clean_high", int'(sig_clean), 1);

      // Reset in the middle of CHK_HI (cnt=2), then re-qualify from scratch.
      step(1'b0);
      sig_raw = 1'b1;
      e0 = cyc;
      q_busy.push_back(mk(e0 + 3, 1));
      tick(4);
      q_busy.push_back(mk(cyc, 0));
`ifdef GLITCH_COUNT_EN
      gexp = 0;
      q_gl.push_back(mk(cyc, 0));
`endif
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_clean", int'(sig_clean), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      e0 = cyc;
      q_busy.push_back(mk(e0 + 3, 1));
      q_busy.push_back(mk(e0 + 6, 0));
      q_clean.push_back(mk(e0 + 6, 1));
      tick(5);
      check("requal_not_early", int'(sig_clean), 0);
      tick(4);

`ifdef GLITCH_COUNT_EN
      // Saturation of a 2-bit glitch counter.
      for (int i = 0; i < 5; i++) begin
         sig_raw2 = 1'b1;
         tick(2);
         sig_raw2 = 1'b0;
         tick(6);
         check("sat_glitch_cnt", int'(glitch_cnt2), (i + 1 > 3) ? 3 : i + 1);
      end
      check("sat_clean_low", int'(clean2), 0);
`endif

      tick(4);
      while (q_clean.size() > 0) begin
         total++; bad++;
         $display("FAIL sig_clean: missing change to %0d at edge %0d", q_clean[0].val, q_clean[0].cyc);
         void'(q_clean.pop_front());
      end
      while (q_busy.size() > 0) begin
         total++; bad++;
         $display("FAIL busy: missing change to %0d at edge %0d", q_busy[0].val, q_busy[0].cyc);
         void'(q_busy.pop_front());
      end
      while (q_gl.size() > 0) begin
         total++; bad++;
         $display("FAIL glitch_cnt: missing change to %0d at edge %0d", q_gl[0].val, q_gl[0].cyc);
         void'(q_gl.pop_front());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
